// File: rtl/framebuffer_arbiter_pkg.sv
// framebuffer_arbiter_pkg
// Shared definitions for the framebuffer arbiter slice:
//   - default geometry / width parameters used by the interface and top
//   - arbiter command-state encoding (S_IDLE, S_VIDEO, S_WRITE)
//   - FRAME_PIXELS, the number of visible pixels (valid write address range)
package framebuffer_arbiter_pkg;

  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_ADDR_WIDTH  = 19;
  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_RD_LATENCY  = 2;
  localparam int DEF_FIFO_DEPTH  = 16;

  // Command state registered one cycle after the counts are evaluated.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VIDEO = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  // Number of visible pixels; any write address at or above this is discarded.
  function automatic int frame_pixels(input int cols, input int rows);
    return cols * rows;
  endfunction

  localparam int FRAME_PIXELS = DEF_ACTIVE_COLS * DEF_ACTIVE_ROWS;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// framebuffer_arbiter_if
// Bundles every non-clock/reset signal of the arbiter.
//   slave  : view of the arbiter (counts, writer, RAM read data in; RAM
//            command, video output, writer status out)
//   master : view of the surrounding system / testbench
// Signals:
//   hsync, vsync, col_count, row_count : timing from the counter stage
//   wr_valid, wr_addr, wr_data, wr_ready, wr_err, fifo_level : pixel writer
//   ram_addr, ram_rd_en, ram_wr_en, ram_wr_data, ram_rd_data : RAM port
//   hsync_out, vsync_out, pixel, pixel_valid : delayed video output
interface framebuffer_arbiter_if
  import framebuffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  hsync;
  logic                  vsync;
  logic [9:0]            col_count;
  logic [9:0]            row_count;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  wr_err;
  logic [LEVEL_W-1:0]    fifo_level;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_rd_en;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  hsync_out;
  logic                  vsync_out;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  pixel_valid;

  modport slave (
    input  hsync, vsync, col_count, row_count,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, wr_err, fifo_level,
    output ram_addr, ram_rd_en, ram_wr_en, ram_wr_data,
    input  ram_rd_data,
    output hsync_out, vsync_out, pixel, pixel_valid
  );

  modport master (
    output hsync, vsync, col_count, row_count,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, wr_err, fifo_level,
    input  ram_addr, ram_rd_en, ram_wr_en, ram_wr_data,
    output ram_rd_data,
    input  hsync_out, vsync_out, pixel, pixel_valid
  );

endinterface

// File: rtl/framebuffer_arbiter_fb_wr_fifo.sv
// fb_wr_fifo
// Synchronous first-word-fall-through FIFO holding pending pixel writes.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (empties FIFO)
//   push/push_data : enqueue request; ignored while full
//   pop/pop_data   : dequeue request; pop_data shows the head entry at all times
//   full, empty    : occupancy flags
//   level          : current number of stored entries (0..DEPTH)
// DEPTH must be a power of two (>= 2).
module fb_wr_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (PW+1)'(DEPTH));
  assign empty    = (level == (PW+1)'(0));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[PW-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= (PW+1)'(0);
      rd_ptr <= (PW+1)'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
// Shares one single-port framebuffer RAM between video scan-out and a pixel
// writer. Each active-video cycle issues a RAM read at the scan pointer;
// buffered writes drain only in blanking cycles. Syncs and pixel-valid are
// delayed RD_LATENCY+2 cycles so they line up with the returned pixel.
// Ports:
//   clk : single clock
//   rst : asynchronous active-high reset
//   bus : framebuffer_arbiter_if.slave (counts/syncs, writer handshake,
//         RAM command/data, delayed video output)
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_LATENCY  = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic clk,
  input logic rst,
  framebuffer_arbiter_if.slave bus
);
  localparam int ENTRY_W   = ADDR_WIDTH + DATA_WIDTH;
  localparam int DLY       = RD_LATENCY + 2;
  localparam int LEVEL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_PIX = frame_pixels(ACTIVE_COLS, ACTIVE_ROWS);
  localparam int CNT_W     = $clog2((TOTAL_COLS > TOTAL_ROWS) ? TOTAL_COLS : TOTAL_ROWS);

  localparam logic [CNT_W-1:0]      ACT_COLS_C  = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0]      ACT_ROWS_C  = CNT_W'(ACTIVE_ROWS);
  localparam logic [ADDR_WIDTH-1:0] FRAME_PIX_C = ADDR_WIDTH'(FRAME_PIX);

  logic [CNT_W-1:0]      col;
  logic [CNT_W-1:0]      row;
  logic                  video;
  logic                  pop;
  logic                  in_range;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LEVEL_W-1:0]    fifo_level;
  logic [ENTRY_W-1:0]    entry;
  logic [ADDR_WIDTH-1:0] entry_addr;
  logic [DATA_WIDTH-1:0] entry_data;

  logic [1:0]            state_r;
  logic                  wr_err_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wr_data_r;
  logic [ADDR_WIDTH-1:0] scan_ptr_r;
  logic [DLY-1:0]        valid_dly_r;
  logic [DLY-1:0]        hsync_dly_r;
  logic [DLY-1:0]        vsync_dly_r;
  logic [DATA_WIDTH-1:0] pixel_r;

  assign col = bus.col_count[CNT_W-1:0];
  assign row = bus.row_count[CNT_W-1:0];

  fb_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_valid),
    .push_data ({bus.wr_addr, bus.wr_data}),
    .pop       (pop),
    .pop_data  (entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign entry_addr = entry[ENTRY_W-1:DATA_WIDTH];
  assign entry_data = entry[DATA_WIDTH-1:0];

  // Slot decision: video always wins; a blanking cycle drains one FIFO entry.
  always_comb begin
    video    = (col < ACT_COLS_C) && (row < ACT_ROWS_C);
    pop      = !video && !fifo_empty;
    in_range = (entry_addr < FRAME_PIX_C);
  end

  // Command register: state, RAM address/data (held in idle), discard flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      wr_err_r      <= 1'b0;
      ram_addr_r    <= {ADDR_WIDTH{1'b0}};
      ram_wr_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_err_r <= 1'b0;
      if (video) begin
        state_r    <= S_VIDEO;
        ram_addr_r <= scan_ptr_r;
      end else if (pop) begin
        state_r <= S_WRITE;
        if (in_range) begin
          ram_addr_r    <= entry_addr;
          ram_wr_data_r <= entry_data;
        end else begin
          // Out-of-range entry is consumed without touching the RAM.
          wr_err_r <= 1'b1;
        end
      end else begin
        state_r <= S_IDLE;
      end
    end
  end

  // Scan pointer: linear read address, cleared throughout vertical blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr_r <= {ADDR_WIDTH{1'b0}};
    end else if (row >= ACT_ROWS_C) begin
      scan_ptr_r <= {ADDR_WIDTH{1'b0}};
    end else if (video) begin
      scan_ptr_r <= scan_ptr_r + ADDR_WIDTH'(1);
    end
  end

  // Delay lines: bit k holds the value sampled k+1 cycles earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_dly_r <= {DLY{1'b0}};
      hsync_dly_r <= {DLY{1'b0}};
      vsync_dly_r <= {DLY{1'b0}};
    end else begin
      valid_dly_r <= {valid_dly_r[DLY-2:0], video};
      hsync_dly_r <= {hsync_dly_r[DLY-2:0], bus.hsync};
      vsync_dly_r <= {vsync_dly_r[DLY-2:0], bus.vsync};
    end
  end

  // Pixel capture: valid_dly_r[RD_LATENCY] marks the cycle read data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_r <= {DATA_WIDTH{1'b0}};
    end else if (valid_dly_r[RD_LATENCY]) begin
      pixel_r <= bus.ram_rd_data;
    end else begin
      pixel_r <= {DATA_WIDTH{1'b0}};
    end
  end

  // Strobes decode directly from registered state; they are mutually exclusive.
  assign bus.ram_rd_en   = (state_r == S_VIDEO);
  assign bus.ram_wr_en   = (state_r == S_WRITE) && !wr_err_r;
  assign bus.ram_addr    = ram_addr_r;
  assign bus.ram_wr_data = ram_wr_data_r;
  assign bus.wr_err      = wr_err_r;
  assign bus.wr_ready    = !fifo_full;
  assign bus.fifo_level  = fifo_level;
  assign bus.pixel       = pixel_r;
  assign bus.pixel_valid = valid_dly_r[DLY-1];
  assign bus.hsync_out   = hsync_dly_r[DLY-1];
  assign bus.vsync_out   = vsync_dly_r[DLY-1];

endmodule
